dcache_port_arb: RTL and testbench

DCACHE_PORT_ARB -- requirements
Module: dcache_port_arb

---
 rtl/dcache_port_arb.sv | 138 +++++++++++++
 tb/tb_dcache_port_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arb.sv
// Arbitrates one D-cache port between LSU loads and store-buffer drains.
// Optional store starvation guard: define DCACHE_ARB_STARVE_GUARD_EN.
module dcache_port_arb #(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        ld_resp,
  output logic [31:0] ld_rdata,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_wmask,
  input  logic [31:0] st_wdata,
  output logic        st_resp,
  input  logic        sb_full,
  input  logic        flush,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_rmask,
  output logic [3:0]  dc_wmask,
  output logic [31:0] dc_wdata,
  input  logic [31:0] dc_rdata,
  input  logic        dc_resp
);

  typedef enum logic [1:0] {IDLE, LD_BUSY, ST_BUSY} state_t;

  state_t      state;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_rmask;
  logic [3:0]  req_wmask;
  logic        kill;

  logic idle;
  logic starve_hit;
  logic st_urgent;
  logic ld_ok;
  logic grant_st;
  logic grant_ld;

  assign idle = (state == IDLE) && !rst;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;

  // Counts every cycle a store waits, including cycles spent busy on loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_st) begin
      starve_cnt <= '0;
    end else if (st_valid && (starve_cnt != 8'hFF)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign starve_hit = ({24'd0, starve_cnt} >= STARVE_LIMIT);
`else
  assign starve_hit = 1'b0;
`endif

  assign st_urgent = st_valid && (sb_full || starve_hit);
  assign ld_ok     = ld_valid && !flush;
  assign grant_st  = idle && (st_urgent || (st_valid && !ld_ok));
  assign grant_ld  = idle && !st_urgent && ld_ok;

  assign ld_ready = grant_ld;
  assign st_ready = grant_st;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      kill      <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_rmask <= '0;
      req_wmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (grant_ld) begin
            state     <= LD_BUSY;
            req_addr  <= ld_addr & 32'hFFFF_FFFC;
            req_rmask <= ld_rmask;
            req_wmask <= 4'd0;
            req_wdata <= 32'd0;
          end else if (grant_st) begin
            state     <= ST_BUSY;
            req_addr  <= st_addr & 32'hFFFF_FFFC;
            req_rmask <= 4'd0;
            req_wmask <= st_wmask;
            req_wdata <= st_wdata;
          end
        end
        LD_BUSY: begin
          if (dc_resp) begin
            state     <= IDLE;
            kill      <= 1'b0;
            req_rmask <= 4'd0;
            req_wmask <= 4'd0;
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (dc_resp) begin
            state     <= IDLE;
            req_rmask <= 4'd0;
            req_wmask <= 4'd0;
          end
        end
        default: begin
          state     <= IDLE;
          kill      <= 1'b0;
          req_rmask <= 4'd0;
          req_wmask <= 4'd0;
        end
      endcase
    end
  end

  // A flush in the response cycle itself also suppresses the load response.
  assign ld_resp  = (state == LD_BUSY) && dc_resp && !kill && !flush && !rst;
  assign ld_rdata = ld_resp ? dc_rdata : 32'd0;
  assign st_resp  = (state == ST_BUSY) && dc_resp && !rst;

  assign dc_addr  = rst ? 32'd0 : req_addr;
  assign dc_wdata = rst ? 32'd0 : req_wdata;
  assign dc_rmask = rst ? 4'd0  : req_rmask;
  assign dc_wmask = rst ? 4'd0  : req_wmask;

endmodule

// File: tb/tb_dcache_port_arb.sv
// Bench for dcache_port_arb: grant model plus transaction scoreboard against a simple cache model.
module tb_dcache_port_arb;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam int SL = 4;
`else
  localparam int SL = 16;
`endif

  logic        clk = 0;
  logic        rst = 1;
  logic        ld_valid = 0, ld_ready;
  logic [31:0] ld_addr = 0;
  logic [3:0]  ld_rmask = 0;
  logic        ld_resp;
  logic [31:0] ld_rdata;
  logic        st_valid = 0, st_ready;
  logic [31:0] st_addr = 0;
  logic [3:0]  st_wmask = 0;
  logic [31:0] st_wdata = 0;
  logic        st_resp;
  logic        sb_full = 0, flush = 0;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_rmask, dc_wmask;
  logic [31:0] dc_rdata = 0;
  logic        dc_resp = 0;

  dcache_port_arb #(.STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
    .ld_resp(ld_resp), .ld_rdata(ld_rdata),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_wmask(st_wmask),
    .st_wdata(st_wdata), .st_resp(st_resp),
    .sb_full(sb_full), .flush(flush),
    .dc_addr(dc_addr), .dc_rmask(dc_rmask), .dc_wmask(dc_wmask), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int n_ld_resp = 0, n_st_resp = 0, n_st_hs = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cache model: answers a request after `lat` extra cycles.
  int   lat = 1;
  int   age = 0;
  bit   force_rd = 0;
  bit   spur = 0;
  logic [31:0] force_val = 32'h0;

  function automatic logic [31:0] cache_data(input logic [31:0] a);
    return force_rd ? force_val : (a ^ 32'h5A5A_0F0F);
  endfunction

  always @(posedge clk) begin
    cyc++;
    #2;
    if (rst) begin
      dc_resp = 0; age = 0;
    end else if (dc_resp) begin
      dc_resp = 0; age = 0;
    end else if (dc_rmask != 0 || dc_wmask != 0) begin
      if (age >= lat) begin
        dc_resp = 1; dc_rdata = cache_data(dc_addr);
      end else begin
        age++;
      end
    end else if (spur) begin
      dc_resp = 1; dc_rdata = 32'hBAD0_BAD0;
    end
  end

  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    bit          kill;
  } txn_t;

  txn_t q[$];
  int   st_wait = 0;

  // Grant model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    bit   hit, e_st, e_ld;
    txn_t t;
    if (ld_resp) n_ld_resp++;
    if (st_resp) n_st_resp++;
    if (st_valid && st_ready) n_st_hs++;
    if (rst) begin
      check_eq("rst_out", {20'd0, ld_ready, st_ready, ld_resp, st_resp, dc_rmask, dc_wmask,
                           dc_addr, dc_wdata, ld_rdata}, 128'd0);
      q.delete();
      st_wait = 0;
    end else if (q.size() != 0) begin
      if (flush && !q[0].st) q[0].kill = 1;
      t = q[0];
      check_eq("busy_rdy", 128'({ld_ready, st_ready}), 128'd0);
      check_eq("dc_addr", 128'(dc_addr), 128'(t.addr));
      check_eq("dc_rmask", 128'(dc_rmask), t.st ? 128'd0 : 128'(t.mask));
      check_eq("dc_wmask", 128'(dc_wmask), t.st ? 128'(t.mask) : 128'd0);
      if (t.st) check_eq("dc_wdata", 128'(dc_wdata), 128'(t.wdata));
      if (dc_resp) begin
        check_eq("ld_resp", 128'(ld_resp), 128'(!t.st && !t.kill));
        check_eq("ld_rdata", 128'(ld_rdata), (!t.st && !t.kill) ? 128'(cache_data(t.addr)) : 128'd0);
        check_eq("st_resp", 128'(st_resp), 128'(t.st));
        void'(q.pop_front());
      end else begin
        check_eq("busy_noresp", 128'({ld_resp, st_resp, ld_rdata}), 128'd0);
      end
      if (st_valid && st_wait < 255) st_wait++;
    end else begin
`ifdef DCACHE_ARB_STARVE_GUARD_EN
      hit = (st_wait >= SL);
`else
      hit = 0;
`endif
      e_st = st_valid && (sb_full || hit);
      e_ld = !e_st && ld_valid && !flush;
      if (!e_ld && st_valid) e_st = 1;
      check_eq("ld_ready", 128'(ld_ready), 128'(e_ld));
      check_eq("st_ready", 128'(st_ready), 128'(e_st));
      check_eq("idle_dc", 128'({dc_rmask, dc_wmask}), 128'd0);
      check_eq("idle_resp", 128'({ld_resp, st_resp, ld_rdata}), 128'd0);
      if (e_ld) q.push_back('{st: 0, addr: ld_addr & 32'hFFFF_FFFC, mask: ld_rmask, wdata: 32'd0, kill: 0});
      if (e_st) q.push_back('{st: 1, addr: st_addr & 32'hFFFF_FFFC, mask: st_wmask, wdata: st_wdata, kill: 0});
      if (e_st) st_wait = 0;
      else if (st_valid && st_wait < 255) st_wait++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input bit st, input int lim, output int at);
    bit got;
    got = 0;
    at  = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (st ? (st_valid && st_ready) : (ld_valid && ld_ready)) begin
        got = 1; at = cyc; break;
      end
    end
    check_eq(st ? "st_hs" : "ld_hs", 128'(got), 128'd1);
    tick();
  endtask

  task automatic wait_resp(input int lim);
    bit got;
    got = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (dc_resp) begin got = 1; break; end
    end
    check_eq("resp_wait", 128'(got), 128'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, r0, s0, n;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    check_eq("after_rst", 128'({dc_addr, dc_wdata, dc_rmask, dc_wmask, ld_rdata}), 128'd0);
    tick();

    // Load wins over a non-urgent store; store waits for the load to finish.
    ld_valid = 1; ld_addr = 32'h0000_0100; ld_rmask = 4'h3;
    st_valid = 1; st_addr = 32'h0000_0200; st_wmask = 4'hC; st_wdata = 32'h1111_2222;
    wait_hs(0, 1, t0);
    ld_valid = 0;
    r0 = n_ld_resp;
    @(negedge clk);
    check_eq("ld_grant1_rmask", 128'(dc_rmask), 128'h3);
    wait_hs(1, 6, t1);
    check_eq("st_after_ldresp", 128'(n_ld_resp), 128'(r0 + 1));
    st_valid = 0;
    wait_resp(6);

    // sb_full forces the store ahead of a pending load.
    ld_valid = 1; ld_addr = 32'h0000_0340; ld_rmask = 4'hF;
    st_valid = 1; st_addr = 32'h0000_0404; st_wmask = 4'hF; st_wdata = 32'hDEAD_BEEF;
    sb_full = 1;
    s0 = n_st_resp;
    wait_hs(1, 1, t0);
    st_valid = 0; sb_full = 0;
    @(negedge clk);
    check_eq("st_wmask", 128'(dc_wmask), 128'hF);
    check_eq("st_wdata", 128'(dc_wdata), 128'hDEAD_BEEF);
    wait_hs(0, 5, t1);
    check_eq("st_resp_cnt", 128'(n_st_resp), 128'(s0 + 1));
    ld_valid = 0;
    wait_resp(6);

    // Flush during a load kills its response; load blocked by flush in IDLE.
    lat = 3; force_rd = 1; force_val = 32'h1234_5678;
    ld_valid = 1; ld_addr = 32'h0000_1000; ld_rmask = 4'hF;
    wait_hs(0, 1, t0);
    ld_valid = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    tick();
    @(negedge clk);
    check_eq("kill_ld_resp", 128'({ld_resp, ld_rdata}), 128'd0);
    tick();
    flush = 1; ld_valid = 1; ld_addr = 32'h0000_1004;
    @(negedge clk);
    check_eq("flush_blocks_ld", 128'(ld_ready), 128'd0);
    tick();
    flush = 0;
    @(negedge clk);
    check_eq("idle_after_kill", 128'(ld_ready), 128'd1);
    tick();
    ld_valid = 0;
    wait_resp(8);
    force_rd = 0; lat = 1;

    // Spurious dc_resp in IDLE must be ignored.
    spur = 1;
    tick();
    spur = 0;
    repeat (2) tick();

    // Continuous loads against a waiting store.
    ld_valid = 1; ld_addr = 32'h0000_0500; ld_rmask = 4'h1;
    st_valid = 1; st_addr = 32'h0000_0600; st_wmask = 4'h3; st_wdata = 32'hCAFE_0001;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
    wait_hs(1, SL + 3, t0);
`else
    s0 = n_st_hs;
    repeat (20) tick();
    check_eq("store_starved", 128'(n_st_hs), 128'(s0));
    sb_full = 1;
    wait_hs(1, 4, t0);
    sb_full = 0;
`endif
    st_valid = 0; ld_valid = 0;
    wait_resp(6);
    repeat (2) tick();

    // Reset in the middle of a store abandons it; the retry completes.
    lat = 3;
    st_valid = 1; st_addr = 32'h0000_0700; st_wmask = 4'hF; st_wdata = 32'h0BAD_F00D;
    wait_hs(1, 1, t0);
    st_valid = 0;
    s0 = n_st_resp;
    tick();
    rst = 1;
    tick();
    rst = 0; st_valid = 1;
    @(negedge clk);
    check_eq("rst_abort_dc", 128'({dc_rmask, dc_wmask}), 128'd0);
    check_eq("rst_no_stresp", 128'(n_st_resp), 128'(s0));
    check_eq("rst_idle", 128'(st_ready), 128'd1);
    tick();
    st_valid = 0;
    wait_resp(8);
    check_eq("retry_stresp", 128'(n_st_resp), 128'(s0 + 1));
    lat = 1;

    // Address alignment and back-to-back grant spacing.
    ld_valid = 1; ld_addr = 32'h0000_2003; ld_rmask = 4'hF;
    wait_hs(0, 1, t0);
    @(negedge clk);
    check_eq("aligned_addr", 128'(dc_addr), 128'h2000);
    wait_hs(0, 5, t1);
    check_eq("b2b_spacing", 128'(t1 - t0), 128'd3);
    n = 0;
    ld_valid = 0;
    wait_resp(6);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
